// File: rtl/alu_op_sequencer.sv
// Command sequencer for a combinational ALU: register-file operand fetch, ALU issue/capture,
// writeback and a valid/ready response, with a stored carry flag for multi-word add/sub.
module alu_op_sequencer #(
  parameter int WIDTH = 4,
  parameter int REGS  = 4,
  parameter int RIDX  = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [RIDX-1:0]  cmd_dst,
  input  logic [RIDX-1:0]  cmd_srca,
  input  logic [RIDX-1:0]  cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_use_imm,
  input  logic             cmd_use_cy,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_carryin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_extra,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic [WIDTH-1:0] rsp_extra,
  output logic             rsp_err,
  output logic             carry_flag
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_LOAD = 4'b1111;

  // ALU extra is only meaningful for the arithmetic/shift ops; logic ops leave it stale.
  function automatic logic op_has_extra(input logic [3:0] op);
    case (op)
      4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011: op_has_extra = 1'b1;
      default:                                     op_has_extra = 1'b0;
    endcase
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] regs_r [REGS];
  logic             carry_flag_r, carry_flag_nxt_s;
  logic [3:0]       alu_opcode_r, alu_opcode_nxt_s;
  logic [WIDTH-1:0] alu_a_r, alu_a_nxt_s;
  logic [WIDTH-1:0] alu_b_r, alu_b_nxt_s;
  logic             alu_carryin_r, alu_carryin_nxt_s;
  logic [WIDTH-1:0] rsp_out_r, rsp_out_nxt_s;
  logic [WIDTH-1:0] rsp_extra_r, rsp_extra_nxt_s;
  logic             rsp_err_r, rsp_err_nxt_s;
  logic [RIDX-1:0]  dst_r, dst_nxt_s;
  logic             rsp_valid_r, cmd_ready_r;
  logic             reg_we_s;
  logic [RIDX-1:0]  reg_widx_s;
  logic [WIDTH-1:0] reg_wdata_s;
  logic [WIDTH-1:0] opnd_a_s, opnd_b_s;
  logic             opnd_cy_s, accept_s, is_rsvd_s, div_zero_s;

  // Operands come from committed register state, so dst may alias a source safely.
  assign opnd_a_s   = regs_r[cmd_srca];
  assign opnd_b_s   = cmd_use_imm ? cmd_imm : regs_r[cmd_srcb];
  assign opnd_cy_s  = cmd_use_cy & carry_flag_r;
  assign accept_s   = cmd_valid & cmd_ready_r;
  assign is_rsvd_s  = (cmd_op == 4'b1100) | (cmd_op == 4'b1101) | (cmd_op == 4'b1110);
  assign div_zero_s = (cmd_op == OP_DIV) & (opnd_b_s == {WIDTH{1'b0}});

  // Next-state, datapath and register-file write decode.
  always_comb begin
    state_nxt_s       = state_r;
    carry_flag_nxt_s  = carry_flag_r;
    alu_opcode_nxt_s  = alu_opcode_r;
    alu_a_nxt_s       = alu_a_r;
    alu_b_nxt_s       = alu_b_r;
    alu_carryin_nxt_s = alu_carryin_r;
    rsp_out_nxt_s     = rsp_out_r;
    rsp_extra_nxt_s   = rsp_extra_r;
    rsp_err_nxt_s     = rsp_err_r;
    dst_nxt_s         = dst_r;
    reg_we_s          = 1'b0;
    reg_widx_s        = dst_r;
    reg_wdata_s       = alu_out;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (cmd_op == OP_LOAD) begin
            reg_we_s        = 1'b1;
            reg_widx_s      = cmd_dst;
            reg_wdata_s     = cmd_imm;
            rsp_out_nxt_s   = cmd_imm;
            rsp_extra_nxt_s = {WIDTH{1'b0}};
            rsp_err_nxt_s   = 1'b0;
            state_nxt_s     = ST_RESP;
          end else if (is_rsvd_s || div_zero_s) begin
            rsp_out_nxt_s   = {WIDTH{1'b0}};
            rsp_extra_nxt_s = {WIDTH{1'b0}};
            rsp_err_nxt_s   = 1'b1;
            state_nxt_s     = ST_RESP;
          end else begin
            alu_opcode_nxt_s  = cmd_op;
            alu_a_nxt_s       = opnd_a_s;
            alu_b_nxt_s       = opnd_b_s;
            alu_carryin_nxt_s = opnd_cy_s;
            dst_nxt_s         = cmd_dst;
            state_nxt_s       = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        reg_we_s        = 1'b1;
        rsp_out_nxt_s   = alu_out;
        rsp_extra_nxt_s = op_has_extra(alu_opcode_r) ? alu_extra : {WIDTH{1'b0}};
        rsp_err_nxt_s   = 1'b0;
        if ((alu_opcode_r == OP_ADD) || (alu_opcode_r == OP_SUB)) begin
          carry_flag_nxt_s = alu_extra[0];
        end else begin
          carry_flag_nxt_s = carry_flag_r;
        end
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, flag and handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag_r  <= 1'b0;
      alu_opcode_r  <= 4'b0000;
      alu_a_r       <= {WIDTH{1'b0}};
      alu_b_r       <= {WIDTH{1'b0}};
      alu_carryin_r <= 1'b0;
      rsp_out_r     <= {WIDTH{1'b0}};
      rsp_extra_r   <= {WIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      dst_r         <= {RIDX{1'b0}};
      rsp_valid_r   <= 1'b0;
      cmd_ready_r   <= 1'b1;
    end else begin
      carry_flag_r  <= carry_flag_nxt_s;
      alu_opcode_r  <= alu_opcode_nxt_s;
      alu_a_r       <= alu_a_nxt_s;
      alu_b_r       <= alu_b_nxt_s;
      alu_carryin_r <= alu_carryin_nxt_s;
      rsp_out_r     <= rsp_out_nxt_s;
      rsp_extra_r   <= rsp_extra_nxt_s;
      rsp_err_r     <= rsp_err_nxt_s;
      dst_r         <= dst_nxt_s;
      rsp_valid_r   <= (state_nxt_s == ST_RESP);
      cmd_ready_r   <= (state_nxt_s == ST_IDLE);
    end
  end

  // Register file; an aborted command never reaches its writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_r[reg_widx_s] <= reg_wdata_s;
    end else begin
      regs_r <= regs_r;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign alu_opcode  = alu_opcode_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_carryin = alu_carryin_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_out     = rsp_out_r;
  assign rsp_extra   = rsp_extra_r;
  assign rsp_err     = rsp_err_r;
  assign carry_flag  = carry_flag_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached to its ALU ports.
module tb_alu_op_sequencer;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
  logic [3:0] cmd_imm;
  logic       cmd_use_imm, cmd_use_cy;
  logic [3:0] alu_opcode, alu_a, alu_b;
  logic       alu_carryin;
  logic [3:0] alu_out, alu_extra;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_out, rsp_extra;
  logic       rsp_err, carry_flag;

  int checks = 0;
  int errors = 0;
  int lat;

  alu_op_sequencer #(.WIDTH(4), .REGS(4), .RIDX(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm), .cmd_use_cy(cmd_use_cy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carryin(alu_carryin),
    .alu_out(alu_out), .alu_extra(alu_extra),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_extra(rsp_extra), .rsp_err(rsp_err), .carry_flag(carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: logic ops leave a non-zero junk extra on purpose.
  always_comb begin
    logic [4:0] wide;
    logic [7:0] prod;
    wide = 5'd0;
    prod = 8'd0;
    case (alu_opcode)
      4'b0000: begin alu_out = alu_a & alu_b; alu_extra = alu_a ^ alu_b; end
      4'b0111: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carryin};
        alu_out = wide[3:0]; alu_extra = {3'd0, wide[4]};
      end
      4'b1000: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_carryin};
        alu_out = wide[3:0]; alu_extra = {3'd0, wide[4]};
      end
      4'b1001: begin
        prod = {4'd0, alu_a} * {4'd0, alu_b};
        alu_out = prod[7:4]; alu_extra = prod[3:0];
      end
      4'b1010: begin
        alu_out   = (alu_b != 4'd0) ? alu_a / alu_b : 4'd0;
        alu_extra = (alu_b != 4'd0) ? alu_a % alu_b : 4'd0;
      end
      4'b1011: begin
        prod = {4'd0, alu_a} << alu_b;
        alu_out = prod[3:0]; alu_extra = prod[7:4];
      end
      default: begin alu_out = alu_a | alu_b; alu_extra = 4'hF; end
    endcase
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command, wait for acceptance, then count negedges until rsp_valid.
  task automatic run_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [3:0] imm, input logic ui,
                         input logic uc, output int l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", 4'(cmd_ready), 4'd1);
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
    cmd_imm = imm; cmd_use_imm = ui; cmd_use_cy = uc;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    l = 0;
    @(negedge clk);
    while (!rsp_valid && l < 10) begin
      @(negedge clk);
      l++;
    end
    chk("rsp_valid_wait", 4'(rsp_valid), 4'd1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = 4'd0; cmd_dst = 2'd0; cmd_srca = 2'd0; cmd_srcb = 2'd0;
    cmd_imm = 4'd0; cmd_use_imm = 1'b0; cmd_use_cy = 1'b0;
    #12;
    chk("rst_rsp_valid", 4'(rsp_valid), 4'd0);
    chk("rst_cmd_ready", 4'(cmd_ready), 4'd1);
    chk("rst_carry", 4'(carry_flag), 4'd0);
    chk("rst_alu_opcode", alu_opcode, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register readback after reset: rN = rN + 0
    for (int i = 0; i < 4; i++) begin
      run_cmd(4'b0111, 2'(i), 2'(i), 2'd0, 4'd0, 1'b1, 1'b0, lat);
      chk("rst_reg_readback", rsp_out, 4'd0);
      ack();
    end

    // Loads and chained add
    run_cmd(4'b1111, 2'd0, 2'd0, 2'd0, 4'hA, 1'b1, 1'b0, lat);
    chk("load_lat", 4'(lat), 4'd0);
    chk("load_out", rsp_out, 4'hA);
    chk("load_err", 4'(rsp_err), 4'd0);
    ack();
    run_cmd(4'b1111, 2'd1, 2'd0, 2'd0, 4'h7, 1'b1, 1'b0, lat);
    chk("load2_out", rsp_out, 4'h7);
    ack();
    run_cmd(4'b0111, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0, lat);
    chk("add_lat", 4'(lat), 4'd2);
    chk("add_out", rsp_out, 4'h1);
    chk("add_extra", rsp_extra, 4'h1);
    chk("add_carry", 4'(carry_flag), 4'd1);
    ack();
    run_cmd(4'b0111, 2'd3, 2'd1, 2'd0, 4'd0, 1'b1, 1'b1, lat);
    chk("addc_out", rsp_out, 4'h8);
    chk("addc_carry", 4'(carry_flag), 4'd0);
    ack();
    run_cmd(4'b1000, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0, lat);
    chk("sub_out", rsp_out, 4'hD);
    chk("sub_borrow", 4'(carry_flag), 4'd1);
    ack();

    // Divide, divide by zero
    run_cmd(4'b1111, 2'd0, 2'd0, 2'd0, 4'hA, 1'b1, 1'b0, lat);
    ack();
    run_cmd(4'b1010, 2'd2, 2'd0, 2'd0, 4'd3, 1'b1, 1'b0, lat);
    chk("div_out", rsp_out, 4'h3);
    chk("div_rem", rsp_extra, 4'h1);
    ack();
    run_cmd(4'b1010, 2'd2, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0, lat);
    chk("div0_err", 4'(rsp_err), 4'd1);
    chk("div0_lat", 4'(lat), 4'd0);
    chk("div0_out", rsp_out, 4'd0);
    ack();
    run_cmd(4'b0000, 2'd2, 2'd2, 2'd0, 4'hF, 1'b1, 1'b0, lat);
    chk("div0_dst_kept", rsp_out, 4'h3);
    chk("and_extra_zero", rsp_extra, 4'd0);
    chk("and_carry_kept", 4'(carry_flag), 4'd1);
    ack();

    // Multiply, AND, reserved op
    run_cmd(4'b1001, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0, lat);
    chk("mul_out", rsp_out, 4'h4);
    chk("mul_extra", rsp_extra, 4'h6);
    ack();
    run_cmd(4'b0000, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0, lat);
    chk("and_out", rsp_out, 4'h2);
    chk("and_extra", rsp_extra, 4'd0);
    ack();
    run_cmd(4'b1100, 2'd0, 2'd1, 2'd0, 4'd5, 1'b1, 1'b0, lat);
    chk("rsvd_err", 4'(rsp_err), 4'd1);
    chk("rsvd_lat", 4'(lat), 4'd0);
    chk("rsvd_alu_op_held", alu_opcode, 4'b0000);
    chk("rsvd_alu_a_held", alu_a, 4'hA);
    ack();
    run_cmd(4'b0000, 2'd0, 2'd0, 2'd0, 4'hF, 1'b1, 1'b0, lat);
    chk("rsvd_reg_kept", rsp_out, 4'hA);
    ack();

    // Response back-pressure
    rsp_ready = 1'b0;
    run_cmd(4'b0111, 2'd1, 2'd1, 2'd0, 4'd1, 1'b1, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 4'(rsp_valid), 4'd1);
      chk("bp_rsp_out", rsp_out, 4'h8);
      chk("bp_cmd_ready", 4'(cmd_ready), 4'd0);
    end
    chk("bp_carry", 4'(carry_flag), 4'd0);
    ack();

    // Reset while the command sits in CAPTURE
    @(negedge clk);
    chk("abort_ready", 4'(cmd_ready), 4'd1);
    cmd_op = 4'b0111; cmd_dst = 2'd2; cmd_srca = 2'd0; cmd_srcb = 2'd1;
    cmd_use_imm = 1'b0; cmd_use_cy = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 4'(rsp_valid), 4'd0);
    chk("abort_carry", 4'(carry_flag), 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(4'b0000, 2'd2, 2'd2, 2'd0, 4'hF, 1'b1, 1'b0, lat);
    chk("abort_dst_zero", rsp_out, 4'd0);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
